seg_scan_ctrl: RTL and testbench
================================

// Module: seg_scan_ctrl
// PURPOSE
//   Time-multiplexes NUM_DIGITS 4-bit hex/BCD values onto one shared 7-segment decoder and common-anode digits.
//   Drives bcd_out to the vending-machine 7-segment decoder and an_n to the digit anodes.
//   Adds an anti-ghosting dead gap between digits.
//   New values are double-buffered and applied only at a frame boundary, so a frame never shows mixed values.
// PARAMETERS
//   NUM_DIGITS   4      digits scanned per frame (2..8)
//   REFRESH_DIV  50000  clk cycles a digit stays lit (>=1)
//   GAP_CYCLES   2      clk cycles all anodes are off between digits (0 = no gap)
//   CNT_W        16     width of the dwell counter; must hold max(REFRESH_DIV, GAP_CYCLES)
// PORTS
//   clk        in   1             system clock, rising edge
//   rst_n      in   1             asynchronous, active-low reset
//   en         in   1             1 = scan; 0 = all digits dark
//   load       in   1             1-cycle strobe: capture digits_in into the pending buffer
//   digits_in  in   4*NUM_DIGITS  digit i = digits_in[4i+3:4i]; digit 0 = rightmost
//   blank_mask in   NUM_DIGITS    1 = keep that digit dark during its slot
//   bcd_out    out  4             nibble to the 7-segment decoder
//   an_n       out  NUM_DIGITS    active-low anode enables; at most one bit is 0
//   frame_tick out  1             1-cycle pulse when the digit index wraps to 0
//   upd_done   out  1             1-cycle pulse when pending values become active
// BEHAVIOUR
//   Reset (async, rst_n=0):
//     - an_n = all 1; bcd_out, frame_tick, upd_done = 0.
//     - Active and pending buffers = 0; upd_pend = 0; idx = 0; counter = 0; state = IDLE.
//   Outputs: all registered. an_n and bcd_out change on the same edge.
//   FSM states: IDLE, LIT, GAP.
//     - IDLE: an_n all 1.
//       - If upd_pend: commit pending->active next cycle and pulse upd_done.
//       - If en=1: go to LIT, idx = 0, counter = 0.
//     - LIT:
//       - an_n[idx] = 0 unless blank_mask[idx] is 1; bcd_out = active[idx].
//       - After REFRESH_DIV cycles: go to GAP if GAP_CYCLES > 0, else go straight to the next digit.
//     - GAP: an_n all 1; bcd_out holds. After GAP_CYCLES cycles, advance idx and go to LIT.
//   Index advance:
//     - idx = NUM_DIGITS-1 wraps to 0 and pulses frame_tick.
//     - On that wrap, if upd_pend: active <= pending, upd_pend <= 0, upd_done pulses in the same cycle as frame_tick.
//   Load rules:
//     - load=1: pending <= digits_in, upd_pend <= 1.
//     - A load while upd_pend=1 overwrites pending (last write wins); only one upd_done follows.
//     - A load in the same cycle as a commit: the old pending is committed, the new value is captured, upd_pend stays 1.
//   blank_mask is sampled every cycle. Masking only darkens a slot; slot timing is unchanged.
//   en 1->0 at any point: next cycle state = IDLE, an_n all 1, idx = 0, counter = 0, no frame_tick.
//     - Pending and active buffers are kept.
//   Frame period = NUM_DIGITS*(REFRESH_DIV+GAP_CYCLES) cycles.
// CONFIGURATION
//   Macro: SEG_SCAN_LZ_SUPPRESS_EN
//   Defined: leading-zero suppression.
//     - Digit i (i>0) stays dark if active[i] and every more-significant active digit are 0.
//     - Digit 0 is never suppressed.
//     - Suppression is ORed with blank_mask.
//   Undefined: all unmasked digits light, including leading zeros.
//     - No extra logic is built.
// TESTING
//   Bench parameters: NUM_DIGITS=4, REFRESH_DIV=4, GAP_CYCLES=1.
//   1. Reset with en=1 held.
//      -> an_n=4'b1111 and bcd_out=0 during reset.
//      -> After release: an_n=1110 for 4 cycles, 1111 for 1 cycle, then 1101.
//      -> frame_tick every 20 cycles.
//   2. load digits_in=16'h1234 mid-frame.
//      -> bcd_out shows the old values until wrap.
//      -> upd_done and frame_tick pulse together.
//      -> Next frame bcd_out = 4,3,2,1 for digits 0..3.
//   3. Two loads, 16'h1111 then 16'h2222, in the same frame.
//      -> Exactly one upd_done; the frame shows 2,2,2,2.
//   4. blank_mask=4'b0100.
//      -> an_n never 1011; digit 2's slot stays all-1 for 4 cycles; frame period is still 20.
//   5. Deassert en in LIT at idx=2.
//      -> Next cycle an_n=1111.
//      -> Re-assert en: scan restarts at idx=0 with no frame_tick.
//   6. SEG_SCAN_LZ_SUPPRESS_EN defined, active value 16'h0050.
//      -> Digits 3 and 2 stay dark; digit 1 shows 5; digit 0 shows 0.
//      -> Value 16'h0000: only digit 0 lights.

Source files
------------

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with inter-digit dead gap and frame-aligned double buffering.
// Optional leading-zero suppression is built when SEG_SCAN_LZ_SUPPRESS_EN is defined.
module seg_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic                    frame_tick,
  output logic                    upd_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [CNT_W-1:0]      DIV_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0]      GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT  = NUM_DIGITS'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LIT  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t                    state_r;
  logic [IDX_W-1:0]          idx_r;
  logic [CNT_W-1:0]          cnt_r;
  logic [4*NUM_DIGITS-1:0]   active_r;
  logic [4*NUM_DIGITS-1:0]   pending_r;
  logic                      upd_pend_r;
  logic [NUM_DIGITS-1:0]     an_n_r;
  logic [3:0]                bcd_r;
  logic                      frame_tick_r;
  logic                      upd_done_r;

  logic [IDX_W-1:0]          idx_nx_s;
  logic                      slot_end_s;
  logic                      wrap_s;
  logic                      commit_s;
  logic [4*NUM_DIGITS-1:0]   active_nx_s;

  function automatic logic [3:0] nib(input logic [4*NUM_DIGITS-1:0] act,
                                     input logic [IDX_W-1:0] i);
    nib = act[{i, 2'b00} +: 4];
  endfunction

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
  // Dark when this digit and every more-significant digit are zero; digit 0 always lights.
  function automatic logic lz_dark(input logic [IDX_W-1:0] i,
                                   input logic [4*NUM_DIGITS-1:0] act);
    logic nz;
    nz = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if ((j >= int'(i)) && (act[4*j +: 4] != 4'd0)) begin
        nz = 1'b1;
      end else begin
        nz = nz;
      end
    end
    lz_dark = (i != IDX_W'(0)) && !nz;
  endfunction
`endif

  function automatic logic [NUM_DIGITS-1:0] slot_an(input logic [IDX_W-1:0] i,
                                                    input logic [NUM_DIGITS-1:0] blank,
                                                    input logic [4*NUM_DIGITS-1:0] act);
    logic dark;
    dark = blank[i];
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    dark = dark | lz_dark(i, act);
`else
    dark = dark | (act[0] & 1'b0);
`endif
    slot_an = dark ? {NUM_DIGITS{1'b1}} : ~(ONE_HOT << i);
  endfunction

  // Slot-end, frame-wrap and buffer-commit decisions for the current cycle.
  always_comb begin
    idx_nx_s   = (idx_r == IDX_LAST) ? IDX_W'(0) : idx_r + IDX_W'(1);
    slot_end_s = 1'b0;
    case (state_r)
      LIT:     slot_end_s = en && (cnt_r == DIV_LAST) && (GAP_CYCLES == 0);
      GAP:     slot_end_s = en && (cnt_r == GAP_LAST);
      default: slot_end_s = 1'b0;
    endcase
    wrap_s      = slot_end_s && (idx_r == IDX_LAST);
    commit_s    = upd_pend_r && (wrap_s || (state_r == IDLE));
    active_nx_s = commit_s ? pending_r : active_r;
  end

  // Scan FSM, buffers and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      idx_r        <= '0;
      cnt_r        <= '0;
      active_r     <= '0;
      pending_r    <= '0;
      upd_pend_r   <= 1'b0;
      an_n_r       <= '1;
      bcd_r        <= 4'd0;
      frame_tick_r <= 1'b0;
      upd_done_r   <= 1'b0;
    end else begin
      frame_tick_r <= 1'b0;
      upd_done_r   <= commit_s;
      active_r     <= active_nx_s;
      // A load coinciding with a commit keeps the request alive for the new value.
      if (load) begin
        pending_r  <= digits_in;
        upd_pend_r <= 1'b1;
      end else if (commit_s) begin
        upd_pend_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          an_n_r <= '1;
          idx_r  <= '0;
          cnt_r  <= '0;
          if (en) begin
            state_r <= LIT;
            an_n_r  <= slot_an(IDX_W'(0), blank_mask, active_nx_s);
            bcd_r   <= nib(active_nx_s, IDX_W'(0));
          end
        end
        LIT: begin
          if (!en) begin
            state_r <= IDLE;
            an_n_r  <= '1;
            idx_r   <= '0;
            cnt_r   <= '0;
          end else if (cnt_r == DIV_LAST) begin
            cnt_r <= '0;
            if (GAP_CYCLES > 0) begin
              state_r <= GAP;
              an_n_r  <= '1;
            end else begin
              idx_r        <= idx_nx_s;
              an_n_r       <= slot_an(idx_nx_s, blank_mask, active_nx_s);
              bcd_r        <= nib(active_nx_s, idx_nx_s);
              frame_tick_r <= wrap_s;
            end
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            an_n_r <= slot_an(idx_r, blank_mask, active_r);
            bcd_r  <= nib(active_r, idx_r);
          end
        end
        GAP: begin
          if (!en) begin
            state_r <= IDLE;
            an_n_r  <= '1;
            idx_r   <= '0;
            cnt_r   <= '0;
          end else if (cnt_r == GAP_LAST) begin
            state_r      <= LIT;
            cnt_r        <= '0;
            idx_r        <= idx_nx_s;
            an_n_r       <= slot_an(idx_nx_s, blank_mask, active_nx_s);
            bcd_r        <= nib(active_nx_s, idx_nx_s);
            frame_tick_r <= wrap_s;
          end else begin
            cnt_r  <= cnt_r + CNT_W'(1);
            an_n_r <= '1;
          end
        end
        default: begin
          state_r <= IDLE;
          an_n_r  <= '1;
          idx_r   <= '0;
          cnt_r   <= '0;
        end
      endcase
    end
  end

  assign bcd_out    = bcd_r;
  assign an_n       = an_n_r;
  assign frame_tick = frame_tick_r;
  assign upd_done   = upd_done_r;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Randomized and directed bench for seg_scan_ctrl against a frame-position reference model.
module tb_seg_scan_ctrl;
  localparam int N = 4;
  localparam int R = 4;
  localparam int G = 1;
  localparam int P = N * (R + G);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0000;
  logic [3:0]  blank_mask = 4'h0;
  logic [3:0]  bcd_out;
  logic [3:0]  an_n;
  logic        frame_tick;
  logic        upd_done;

  seg_scan_ctrl #(.NUM_DIGITS(N), .REFRESH_DIV(R), .GAP_CYCLES(G), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load(load), .digits_in(digits_in),
    .blank_mask(blank_mask), .bcd_out(bcd_out), .an_n(an_n),
    .frame_tick(frame_tick), .upd_done(upd_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: scan position within the frame, plus the two value buffers.
  bit          m_scan;
  int          m_pos;
  logic [15:0] m_act, m_pend;
  bit          m_pf;
  logic [3:0]  m_an, m_bcd;
  bit          m_ft, m_ud;

  always @(posedge clk or negedge rst_n) begin
    int slot, ph;
    bit commit, dark;
    if (!rst_n) begin
      m_scan = 0; m_pos = 0; m_act = 16'h0; m_pend = 16'h0; m_pf = 0;
      m_an = 4'hf; m_bcd = 4'h0; m_ft = 0; m_ud = 0;
    end else begin
      commit = 0;
      m_ft = 0;
      if (!m_scan) begin
        if (m_pf) commit = 1;
        if (en) begin m_scan = 1; m_pos = 0; end
      end else if (!en) begin
        m_scan = 0;
      end else if (m_pos == P - 1) begin
        m_pos = 0; m_ft = 1;
        if (m_pf) commit = 1;
      end else begin
        m_pos = m_pos + 1;
      end
      if (commit) begin m_act = m_pend; m_pf = 0; end
      if (load) begin m_pend = digits_in; m_pf = 1; end
      m_ud = commit;
      m_an = 4'hf;
      if (m_scan) begin
        slot = m_pos / (R + G);
        ph = m_pos % (R + G);
        if (ph < R) begin
          m_bcd = 4'((m_act >> (4 * slot)) & 16'hf);
          dark = blank_mask[slot];
`ifdef SEG_SCAN_LZ_SUPPRESS_EN
          if (slot > 0 && (m_act >> (4 * slot)) == 16'h0) dark = 1;
`endif
          if (!dark) m_an = ~(4'b0001 << slot);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("an_n", an_n, m_an);
      check("bcd_out", bcd_out, m_bcd);
      check("frame_tick", frame_tick, m_ft);
      check("upd_done", upd_done, m_ud);
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic pulse_load(input logic [15:0] v);
    digits_in = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic wait_tick(output bit ok);
    ok = 0;
    for (int c = 0; c < 2 * P && !ok; c++) begin
      step();
      if (frame_tick) ok = 1;
    end
  endtask

  task automatic tick_period(output int p);
    bit ok;
    p = 0;
    wait_tick(ok);
    if (ok) begin
      do begin step(); p++; end while (!frame_tick && p <= 2 * P);
    end
  endtask

  // Checks the lit digits over one frame against the given value, starting at the current sample.
  task automatic check_frame(input logic [15:0] val, input string tag);
    logic [3:0] pat;
    for (int c = 0; c < P; c++) begin
      for (int k = 0; k < N; k++) begin
        pat = ~(4'b0001 << k);
        if (an_n == pat) check(tag, bcd_out, 4'((val >> (4 * k)) & 16'hf));
      end
      step();
    end
  endtask

  initial begin
    logic [3:0] boot [6];
    int p, cnt;
    bit ok;
    boot = '{4'he, 4'he, 4'he, 4'he, 4'hf, 4'hd};

    // Reset held with en high.
    repeat (3) begin
      step();
      check("rst_an_n", an_n, 4'hf);
      check("rst_bcd", bcd_out, 4'h0);
      check("rst_ft", frame_tick, 1'b0);
      check("rst_ud", upd_done, 1'b0);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("boot_seq", an_n, boot[i]);
    end
    repeat (2) begin
      tick_period(p);
      check("frame_period", p, P);
    end

    // Mid-frame load commits only at the wrap, together with frame_tick.
    repeat (7) step();
    pulse_load(16'h1234);
    ok = 0;
    for (int c = 0; c < 2 * P && !ok; c++) begin
      if (upd_done) ok = 1; else step();
    end
    check("upd_seen", ok, 1'b1);
    check("upd_with_tick", frame_tick, 1'b1);
    check_frame(16'h1234, "frame_1234");

    // Two loads in one frame: last wins, single upd_done.
    wait_tick(ok);
    repeat (3) step();
    pulse_load(16'h1111);
    repeat (4) step();
    pulse_load(16'h2222);
    cnt = 0;
    ok = 0;
    for (int c = 0; c < 2 * P; c++) begin
      step();
      if (upd_done) cnt++;
      if (upd_done && !ok) begin ok = 1; check_frame(16'h2222, "frame_2222"); c += P; end
    end
    check("upd_count", cnt, 1);

    // Masked digit stays dark, frame timing unchanged.
    blank_mask = 4'b0100;
    cnt = 0;
    for (int c = 0; c < 2 * P; c++) begin
      step();
      if (an_n == 4'b1011) cnt++;
    end
    check("mask_dark", cnt, 0);
    tick_period(p);
    check("mask_period", p, P);
    blank_mask = 4'b0000;

    // Drop en while digit 2 is lit, then restart.
    ok = 0;
    for (int c = 0; c < 3 * P && !ok; c++) begin
      step();
      if (an_n == 4'b1011) ok = 1;
    end
    check("idx2_seen", ok, 1'b1);
    en = 1'b0;
    step();
    check("en_off_an", an_n, 4'hf);
    step();
    check("en_off_ft", frame_tick, 1'b0);
    en = 1'b1;
    step();
    check("restart_an", an_n, 4'he);
    check("restart_ft", frame_tick, 1'b0);

`ifdef SEG_SCAN_LZ_SUPPRESS_EN
    pulse_load(16'h0050);
    wait_tick(ok);
    cnt = 0;
    for (int c = 0; c < P; c++) begin
      if (an_n == 4'b0111 || an_n == 4'b1011) cnt++;
      if (an_n == 4'b1101) check("lz_d1", bcd_out, 4'h5);
      if (an_n == 4'b1110) check("lz_d0", bcd_out, 4'h0);
      step();
    end
    check("lz_dark", cnt, 0);
    pulse_load(16'h0000);
    wait_tick(ok);
    wait_tick(ok);
    cnt = 0;
    for (int c = 0; c < P; c++) begin
      if (an_n != 4'hf && an_n != 4'he) cnt++;
      step();
    end
    check("lz_zero", cnt, 0);
`endif

    // Randomized traffic checked by the model.
    for (int c = 0; c < 3000; c++) begin
      load = ($urandom_range(15) == 0);
      digits_in = 16'($urandom);
      if ($urandom_range(63) == 0) blank_mask = 4'($urandom);
      if ($urandom_range(199) == 0) en = ~en;
      step();
    end
    load = 1'b0;
    en = 1'b1;
    repeat (2 * P) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
